// File: rtl/zoom_pkg.sv
// Shared constants and types for the 1280x720 -> 960x540 bilinear scaler scheduler.
package zoom_pkg;
  localparam int SRC_W    = 1280;
  localparam int SRC_H    = 720;
  localparam int DST_W    = 960;
  localparam int DST_H    = 540;
  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    RUN       = 2'd2,
    LINE_END  = 2'd3
  } state_t;

  // One slot of the marker delay line that travels alongside the read.
  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
    logic eof;
  } mark_t;
endpackage

// File: rtl/zoom_phase_cnt.sv
// Phase 0..2 plus group counter; {group, phase} is a source coordinate that skips 3 mod 4.
module zoom_phase_cnt #(
  parameter int NGRP = 320,
  parameter int GW   = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [1:0]    phase,
  output logic [GW-1:0] group,
  output logic          last
);
  import zoom_pkg::*;

  assign last = (phase == 2'd2) && (group == GW'(NGRP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
      group <= '0;
    end else if (clr) begin
      phase <= 2'd0;
      group <= '0;
    end else if (en) begin
      if (phase == 2'd2) begin
        phase <= 2'd0;
        group <= last ? '0 : group + 1'b1;
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end
endmodule

// File: rtl/zoom_sched.sv
// Destination-raster scheduler: one 2x2 source read per output pixel, phase indices,
// line release counts and a PIPE_LAT-aligned marker stream for the blender.
module zoom_sched #(
  parameter int DST_W    = zoom_pkg::DST_W,
  parameter int DST_H    = zoom_pkg::DST_H,
  parameter int PIPE_LAT = zoom_pkg::PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              line_rdy,
  input  logic              dst_rdy,
  output logic              rd_en,
  output logic [10:0]       rd_x,
  output logic [9:0]        rd_y,
  output logic [1:0]        coef_x,
  output logic [1:0]        coef_y,
  output logic              line_done,
  output logic [1:0]        rel_cnt,
  output logic              out_vld,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output zoom_pkg::state_t  state_dbg
);
  import zoom_pkg::*;

  localparam int XGW = 9;
  localparam int YGW = 8;

  state_t          state, state_nxt;
  logic            x_clr, x_en, y_clr, y_en;
  logic [1:0]      px, py;
  logic [XGW-1:0]  kx;
  logic [YGW-1:0]  ky;
  logic            x_last, y_last;
  mark_t           mk_in;
  mark_t [PIPE_LAT-1:0] mk_pipe;

  zoom_phase_cnt #(.NGRP(DST_W / 3), .GW(XGW)) u_x_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (x_clr),
    .en    (x_en),
    .phase (px),
    .group (kx),
    .last  (x_last)
  );

  zoom_phase_cnt #(.NGRP(DST_H / 3), .GW(YGW)) u_y_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (y_clr),
    .en    (y_en),
    .phase (py),
    .group (ky),
    .last  (y_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake: in RUN a read is issued exactly when dst_rdy is high; a low dst_rdy
  // stalls counters and outputs without dropping a pixel. abort overrides everything.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    line_done = 1'b0;
    rel_cnt   = 2'd0;
    x_clr     = 1'b0;
    x_en      = 1'b0;
    y_clr     = 1'b0;
    y_en      = 1'b0;
    case (state)
      IDLE: begin
        x_clr = 1'b1;
        y_clr = 1'b1;
        if (start) state_nxt = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (line_rdy) state_nxt = RUN;
      end
      RUN: begin
        rd_en = dst_rdy;
        x_en  = dst_rdy;
        if (dst_rdy && x_last) state_nxt = LINE_END;
      end
      LINE_END: begin
        line_done = 1'b1;
        rel_cnt   = (py == 2'd2) ? 2'd2 : 2'd1;
        x_clr     = 1'b1;
        y_en      = 1'b1;
        state_nxt = y_last ? IDLE : WAIT_LINE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      rd_en     = 1'b0;
      line_done = 1'b0;
      rel_cnt   = 2'd0;
      x_en      = 1'b0;
      y_en      = 1'b0;
      x_clr     = 1'b1;
      y_clr     = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign rd_x      = {kx, px};
  assign rd_y      = {ky, py};
  // Phase 0 of x maps to coefficient index 1; the lookup never sees x index 0.
  assign coef_x    = busy ? px + 2'd1 : 2'd0;
  assign coef_y    = py;

  assign mk_in.vld = rd_en;
  assign mk_in.sof = rd_en && (kx == '0) && (px == 2'd0) && (ky == '0) && (py == 2'd0);
  assign mk_in.eol = rd_en && x_last;
  assign mk_in.eof = rd_en && x_last && y_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk_pipe <= '0;
    end else if (abort) begin
      mk_pipe <= '0;
    end else begin
      mk_pipe[0] <= mk_in;
      for (int i = 1; i < PIPE_LAT; i++) mk_pipe[i] <= mk_pipe[i-1];
    end
  end

  assign out_vld = mk_pipe[PIPE_LAT-1].vld;
  assign out_sof = mk_pipe[PIPE_LAT-1].sof;
  assign out_eol = mk_pipe[PIPE_LAT-1].eol;
  assign out_eof = mk_pipe[PIPE_LAT-1].eof;
endmodule

// File: tb/tb_zoom_sched.sv
// Bench for zoom_sched: full-size instance for line/abort boundaries, small instance for whole frames.
module tb_zoom_sched;
  import zoom_pkg::*;

  localparam int NI  = 2;
  localparam int W_B = 960;
  localparam int H_B = 540;
  localparam int W_S = 6;
  localparam int H_S = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic line_rdy = 1'b0;
  logic dst_rdy = 1'b0;
  logic [NI-1:0] start_v = '0;

  logic [NI-1:0] rd_en, line_done, out_vld, out_sof, out_eol, out_eof, busy;
  logic [10:0]   rd_x    [NI];
  logic [9:0]    rd_y    [NI];
  logic [1:0]    coef_x  [NI];
  logic [1:0]    coef_y  [NI];
  logic [1:0]    rel_cnt [NI];
  state_t        st      [NI];

  int checks = 0;
  int errors = 0;

  int n_m [NI];
  int l_m [NI];
  logic [3:0] pipe_m [NI][2];
  logic exp_idle [NI];
  int reads [NI];
  int ldones [NI];
  int vlds [NI];
  int sofs [NI];
  int eofs [NI];
  int eof_at [NI];

  typedef struct {
    int s, lr, dr, ab;
    int st, re, x, y, cx, cy, ld, rel, b;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  zoom_sched #(.DST_W(W_B), .DST_H(H_B), .PIPE_LAT(2)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .line_rdy(line_rdy), .dst_rdy(dst_rdy),
    .rd_en(rd_en[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]),
    .coef_x(coef_x[0]), .coef_y(coef_y[0]),
    .line_done(line_done[0]), .rel_cnt(rel_cnt[0]),
    .out_vld(out_vld[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]), .out_eof(out_eof[0]),
    .busy(busy[0]), .state_dbg(st[0])
  );

  zoom_sched #(.DST_W(W_S), .DST_H(H_S), .PIPE_LAT(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
    .line_rdy(line_rdy), .dst_rdy(dst_rdy),
    .rd_en(rd_en[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]),
    .coef_x(coef_x[1]), .coef_y(coef_y[1]),
    .line_done(line_done[1]), .rel_cnt(rel_cnt[1]),
    .out_vld(out_vld[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]), .out_eof(out_eof[1]),
    .busy(busy[1]), .state_dbg(st[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pos(input int n);
    return 4 * (n / 3) + (n % 3);
  endfunction

  function automatic vec_t v(input int s, lr, dr, ab, stt, re, x, y, cx, cy, ld, rel, b);
    vec_t r;
    r.s = s; r.lr = lr; r.dr = dr; r.ab = ab;
    r.st = stt; r.re = re; r.x = x; r.y = y; r.cx = cx; r.cy = cy;
    r.ld = ld; r.rel = rel; r.b = b;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      n_m[i] = 0;
      l_m[i] = 0;
      pipe_m[i][0] = 4'b0;
      pipe_m[i][1] = 4'b0;
      exp_idle[i] = 1'b0;
    end
  endtask

  task automatic count_clear(input int i);
    reads[i] = 0; ldones[i] = 0; vlds[i] = 0;
    sofs[i] = 0; eofs[i] = 0; eof_at[i] = 0;
  endtask

  // Compare this cycle's outputs of both instances against the raster model.
  task automatic sample();
    for (int i = 0; i < NI; i++) begin
      logic [3:0] mk;
      int w;
      int h;
      w = (i == 0) ? W_B : W_S;
      h = (i == 0) ? H_B : H_S;
      mk = 4'b0;
      chk($sformatf("markers%0d", i),
          32'({out_vld[i], out_sof[i], out_eol[i], out_eof[i]}), 32'(pipe_m[i][1]));
      if (out_vld[i]) begin
        vlds[i]++;
        if (out_sof[i]) sofs[i]++;
        if (out_eof[i]) begin
          eofs[i]++;
          eof_at[i] = vlds[i];
        end
      end
      if (exp_idle[i]) begin
        chk($sformatf("busy_after_frame%0d", i), 32'(busy[i]), 0);
        exp_idle[i] = 1'b0;
      end
      if (abort) chk($sformatf("rd_en_abort%0d", i), 32'(rd_en[i]), 0);
      if (rd_en[i]) begin
        chk($sformatf("rd_x%0d", i), 32'(rd_x[i]), pos(n_m[i]));
        chk($sformatf("rd_y%0d", i), 32'(rd_y[i]), pos(l_m[i]));
        chk($sformatf("coef_x%0d", i), 32'(coef_x[i]), (n_m[i] % 3) + 1);
        chk($sformatf("coef_y%0d", i), 32'(coef_y[i]), l_m[i] % 3);
        mk = {1'b1, (n_m[i] == 0 && l_m[i] == 0), (n_m[i] == w - 1),
              (n_m[i] == w - 1 && l_m[i] == h - 1)};
        n_m[i]++;
        reads[i]++;
      end
      if (line_done[i]) begin
        chk($sformatf("line_reads%0d", i), n_m[i], w);
        chk($sformatf("rel_cnt%0d", i), 32'(rel_cnt[i]), (l_m[i] % 3 == 2) ? 2 : 1);
        n_m[i] = 0;
        l_m[i]++;
        ldones[i]++;
        if (l_m[i] == h) begin
          l_m[i] = 0;
          exp_idle[i] = 1'b1;
        end
      end
      pipe_m[i][1] = pipe_m[i][0];
      pipe_m[i][0] = mk;
      if (abort) begin
        pipe_m[i][0] = 4'b0;
        pipe_m[i][1] = 4'b0;
        n_m[i] = 0;
        l_m[i] = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    sample();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_bits%0d", tag, i),
          32'({rd_en[i], line_done[i], out_vld[i], out_sof[i], out_eol[i], out_eof[i], busy[i]}), 0);
      chk($sformatf("%s_rd_x%0d", tag, i), 32'(rd_x[i]), 0);
      chk($sformatf("%s_rd_y%0d", tag, i), 32'(rd_y[i]), 0);
      chk($sformatf("%s_coef%0d", tag, i), 32'({coef_x[i], coef_y[i]}), 0);
      chk($sformatf("%s_rel%0d", tag, i), 32'(rel_cnt[i]), 0);
      chk($sformatf("%s_state%0d", tag, i), 32'(st[i]), 32'(IDLE));
    end
  endtask

  initial begin
    int done;
    int hold;
    int base;
    logic [10:0] last_x;

    model_clear();
    for (int i = 0; i < NI; i++) count_clear(i);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Table: start, stall, start ignored, line end, line_rdy hold, abort, abort vs start
    tv.push_back(v(1,0,0,0, IDLE,     0, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,0,1,0, WAIT_LINE,0, 0,0, 1,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, WAIT_LINE,0, 0,0, 1,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 0,0, 1,0, 0,0, 1));
    tv.push_back(v(0,1,0,0, RUN,      0, 1,0, 2,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 1,0, 2,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 2,0, 3,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 4,0, 1,0, 0,0, 1));
    tv.push_back(v(1,1,1,0, RUN,      1, 5,0, 2,0, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 6,0, 3,0, 0,0, 1));
    tv.push_back(v(0,0,1,0, LINE_END, 0, 0,0, 1,0, 1,1, 1));
    tv.push_back(v(0,0,1,0, WAIT_LINE,0, 0,1, 1,1, 0,0, 1));
    tv.push_back(v(0,0,1,0, WAIT_LINE,0, 0,1, 1,1, 0,0, 1));
    tv.push_back(v(0,1,1,0, WAIT_LINE,0, 0,1, 1,1, 0,0, 1));
    tv.push_back(v(0,1,1,0, RUN,      1, 0,1, 1,1, 0,0, 1));
    tv.push_back(v(0,1,1,1, RUN,      0, 1,1, 2,1, 0,0, 1));
    tv.push_back(v(0,1,1,0, IDLE,     0, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,1,1,1, IDLE,     0, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,1,1,0, IDLE,     0, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,1,1,0, IDLE,     0, 0,0, 0,0, 0,0, 0));
    for (int k = 0; k < tv.size(); k++) begin
      start_v[1] = (tv[k].s != 0);
      line_rdy   = (tv[k].lr != 0);
      dst_rdy    = (tv[k].dr != 0);
      abort      = (tv[k].ab != 0);
      #1;
      chk($sformatf("tv%0d_state", k), 32'(st[1]), tv[k].st);
      chk($sformatf("tv%0d_rd_en", k), 32'(rd_en[1]), tv[k].re);
      chk($sformatf("tv%0d_rd_x", k), 32'(rd_x[1]), tv[k].x);
      chk($sformatf("tv%0d_rd_y", k), 32'(rd_y[1]), tv[k].y);
      chk($sformatf("tv%0d_coef_x", k), 32'(coef_x[1]), tv[k].cx);
      chk($sformatf("tv%0d_coef_y", k), 32'(coef_y[1]), tv[k].cy);
      chk($sformatf("tv%0d_line_done", k), 32'(line_done[1]), tv[k].ld);
      chk($sformatf("tv%0d_rel_cnt", k), 32'(rel_cnt[1]), tv[k].rel);
      chk($sformatf("tv%0d_busy", k), 32'(busy[1]), tv[k].b);
      sample();
      @(posedge clk);
      #2;
    end
    start_v[1] = 1'b0;
    abort = 1'b0;

    // Small full frame, no stalls
    count_clear(1);
    line_rdy = 1'b1;
    dst_rdy = 1'b1;
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    done = 0;
    for (int c = 0; c < 400 && done == 0; c++) begin
      step();
      if (ldones[1] == H_S && busy[1] == 1'b0) done = 1;
    end
    chk("frame_done", done, 1);
    for (int c = 0; c < 3; c++) step();
    chk("frame_reads", reads[1], W_S * H_S);
    chk("frame_line_done", ldones[1], H_S);
    chk("frame_sof", sofs[1], 1);
    chk("frame_eof", eofs[1], 1);
    chk("frame_eof_at", eof_at[1], W_S * H_S);

    // Small frame with random dst_rdy and 10-cycle line_rdy holds after each line
    count_clear(1);
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    hold = 0;
    done = 0;
    for (int c = 0; c < 3000 && done == 0; c++) begin
      line_rdy = (hold == 0);
      dst_rdy = 1'($urandom_range(0, 1));
      #1;
      if (hold > 0) begin
        chk("hold_state", 32'(st[1]), 32'(WAIT_LINE));
        chk("hold_rd_en", 32'(rd_en[1]), 0);
        hold--;
      end
      if (line_done[1] && l_m[1] != H_S - 1) hold = 10;
      sample();
      @(posedge clk);
      #2;
      if (ldones[1] == H_S) done = 1;
    end
    chk("rand_frame_done", done, 1);
    line_rdy = 1'b1;
    dst_rdy = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("rand_reads", reads[1], W_S * H_S);
    chk("rand_sof", sofs[1], 1);
    chk("rand_eof", eofs[1], 1);
    chk("rand_eof_at", eof_at[1], W_S * H_S);

    // Full-size first line, then abort at rd_x 500 on line 3
    count_clear(0);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    last_x = '0;
    done = 0;
    for (int c = 0; c < 1200 && done == 0; c++) begin
      #1;
      sample();
      if (n_m[0] == W_B) last_x = rd_x[0];
      @(posedge clk);
      #2;
      if (ldones[0] == 1) done = 1;
    end
    chk("big_line0_done", done, 1);
    chk("big_line0_reads", reads[0], 960);
    chk("big_last_rd_x", 32'(last_x), 1278);
    done = 0;
    for (int c = 0; c < 6000 && done == 0; c++) begin
      step();
      if (l_m[0] == 3 && n_m[0] == 375) done = 1;
    end
    chk("big_abort_point", done, 1);
    abort = 1'b1;
    #1;
    chk("abort_rd_x", 32'(rd_x[0]), 500);
    chk("abort_rd_y", 32'(rd_y[0]), 4);
    sample();
    @(posedge clk);
    #2;
    abort = 1'b0;
    #1;
    chk("post_abort_busy", 32'(busy[0]), 0);
    chk("post_abort_rd_en", 32'(rd_en[0]), 0);
    chk("post_abort_out_vld", 32'(out_vld[0]), 0);
    chk("post_abort_rd_x", 32'(rd_x[0]), 0);
    sample();
    @(posedge clk);
    #2;
    base = sofs[0];
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("restart_sof", sofs[0] - base, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Reset mid-RUN on the small instance
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("pre_reset_busy", 32'(busy[1]), 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_clear();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
